reg_bus_master: RTL and testbench
=================================

REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the bus data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the command FIFO entries (power of 2, at least 2).
REQ-004 SHALL have clk  input  1  clock, with all state updating on its rising edge.
REQ-005 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have cmd_valid  input  1  host command present.
REQ-007 SHALL have cmd_ready  output  1  FIFO can accept a command.
REQ-008 SHALL have cmd_wr  input  1  1=write, 0=read.
REQ-009 SHALL have cmd_addr  input  ADDR_WIDTH  target register address.
REQ-010 SHALL have cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have rsp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have rsp_rdata  output  DATA_WIDTH  read data, or 0 on error.
REQ-013 SHALL have rsp_err  output  1  illegal-address response.
REQ-014 SHALL have addr  output  ADDR_WIDTH  bus address.
REQ-015 SHALL have wr_en  output  1  bus write enable.
REQ-016 SHALL have valid  output  1  bus transfer strobe.
REQ-017 SHALL have wdata  output  DATA_WIDTH  bus write data.
REQ-018 SHALL have rdata  input  DATA_WIDTH  bus read data, registered by the responder one edge after the read strobe.
REQ-019 SHALL have busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-020 SHALL have fifo_level  output  clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Function
REQ-021 SHALL push {cmd_wr,cmd_addr,cmd_wdata} into the FIFO on each edge where cmd_valid and cmd_ready are both 1.
REQ-022 SHALL drive cmd_ready = (fifo_level != FIFO_DEPTH), with no push-through when full even if a pop occurs in the same cycle.
REQ-023 SHALL treat only the addresses 0x400, 0x404, 0x408 and 0x40C as legal.
REQ-024 SHALL implement the FSM states IDLE, ISSUE and RD_WAIT.
REQ-025 SHALL, in IDLE with the FIFO non-empty and the head address legal, pop the head, register addr/wr_en/wdata, and go to ISSUE.
REQ-026 SHALL, in IDLE with the FIFO non-empty and the head address illegal, pop the head, stay in IDLE, leave valid at 0, and pulse rsp_valid=1 with rsp_err=1 and rsp_rdata=0 in the cycle after the pop.
REQ-027 SHALL hold valid=1 for exactly one cycle in ISSUE, then go to IDLE if wr_en=1 or to RD_WAIT if wr_en=0.
REQ-028 SHALL, in RD_WAIT, capture rdata on the exiting edge, pulse rsp_valid=1 with rsp_err=0 and rsp_rdata=captured value for one cycle, and go to IDLE.
REQ-029 SHALL generate no response for a legal write.
REQ-030 SHALL keep addr, wr_en and wdata stable from entry to ISSUE until the next pop, and keep valid=0 in all states other than ISSUE.
REQ-031 SHALL meet these latencies, with command accepted at edge E0 and an idle, empty block: valid high E1–E2; read rsp_valid high E3–E4; minimum spacing of 2 cycles between legal writes and 3 cycles between reads.
REQ-032 SHALL allow a simultaneous push and pop in one edge, with fifo_level unchanged and FIFO order preserved.
REQ-033 SHALL hold rsp_rdata and rsp_err at their last values while rsp_valid=0.

Reset
REQ-034 SHALL, on reset assertion, immediately force valid=0, wr_en=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, fifo_level=0 and busy=0.
REQ-035 SHALL, when reset is asserted mid-transaction, discard the in-flight transfer and all queued commands without producing a response.
REQ-036 SHALL drive cmd_ready=1 from the first cycle after reset deasserts.

Verification
REQ-037 SHALL pass this test: write 0x404 data 0xA5A5_0001 -> one valid pulse with wr_en=1, addr=0x404, wdata=0xA5A5_0001, and no rsp_valid.
REQ-038 SHALL pass this test: write 0x408 data 0x1234, then read 0x408 -> rsp_valid one cycle with rsp_rdata=0x1234, rsp_err=0, timed exactly per REQ-031.
REQ-039 SHALL pass this test: read 0x410 -> no valid pulse and rsp_valid with rsp_err=1 and rsp_rdata=0; a read of 0x402 behaves the same.
REQ-040 SHALL pass this test: push 5 back-to-back commands while the FSM is busy -> cmd_ready=0 at fifo_level=4, the 5th command stalls until a pop, and all 5 are issued in order.
REQ-041 SHALL pass this test: hold cmd_valid continuously with alternating reads and writes to 0x400..0x40C -> no lost or duplicated transfers and read-back data matching the last write.
REQ-042 SHALL pass this test: assert reset during ISSUE of a read with 3 entries queued -> valid drops immediately, no rsp_valid, fifo_level=0 and busy=0.

Source files
------------

// File: rtl/reg_bus_master.sv
// Command-FIFO-fed register bus master: queues host reads/writes, issues them one at a time
// on a single-strobe register bus and returns read data or an illegal-address error.
module reg_bus_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_wr,
   input  logic [ADDR_WIDTH-1:0]         cmd_addr,
   input  logic [DATA_WIDTH-1:0]         cmd_wdata,
   output logic                          rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic [ADDR_WIDTH-1:0]         addr,
   output logic                          wr_en,
   output logic                          valid,
   output logic [DATA_WIDTH-1:0]         wdata,
   input  logic [DATA_WIDTH-1:0]         rdata,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [1:0]                    state_dbg
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_RD_WAIT = 2'd2;

   // Legal window is the four word-aligned registers starting at this base.
   localparam logic [ADDR_WIDTH-1:0] REG_BASE = ADDR_WIDTH'(32'h400);

   logic [1:0]            state;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        count;

   logic                  mem_wr    [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] mem_addr  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_wdata [FIFO_DEPTH];

   logic                  push;
   logic                  pop;
   logic                  head_wr;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;
   logic                  head_legal;

   // Host handshake: a command transfers on every rising edge where cmd_valid and
   // cmd_ready are both high; cmd_ready depends only on the registered FIFO level,
   // so a pop in the same cycle never lets a command through a full FIFO.
   assign cmd_ready = (count != (PTR_W+1)'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == ST_IDLE) && (count != '0);

   assign head_wr    = mem_wr[rd_ptr];
   assign head_addr  = mem_addr[rd_ptr];
   assign head_wdata = mem_wdata[rd_ptr];
   assign head_legal = (head_addr[1:0] == 2'b00) && ((head_addr >> 4) == (REG_BASE >> 4));

   assign busy       = (count != '0) || (state != ST_IDLE);
   assign fifo_level = count;
   assign state_dbg  = state;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_wr[wr_ptr]    <= cmd_wr;
         mem_addr[wr_ptr]  <= cmd_addr;
         mem_wdata[wr_ptr] <= cmd_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Bus fields stay put between pops; valid and rsp_valid are single-cycle strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         valid     <= 1'b0;
         wr_en     <= 1'b0;
         addr      <= '0;
         wdata     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         valid     <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  if (head_legal) begin
                     addr  <= head_addr;
                     wr_en <= head_wr;
                     wdata <= head_wdata;
                     valid <= 1'b1;
                     state <= ST_ISSUE;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end
               end
            end
            ST_ISSUE: begin
               state <= wr_en ? ST_IDLE : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= rdata;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: a registered four-register responder on the bus,
// a monitor collecting bus strobes and responses, and an in-order expected model.
module tb_reg_bus_master;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_wr;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] addr;
   logic          wr_en;
   logic          valid;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata = '0;
   logic          busy;
   logic [2:0]    fifo_level;
   logic [1:0]    state_dbg;

   reg_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .addr(addr), .wr_en(wr_en), .valid(valid), .wdata(wdata), .rdata(rdata),
      .busy(busy), .fifo_level(fifo_level), .state_dbg(state_dbg)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
      $fatal(1);
   end

   // registered responder: read data appears one edge after the strobe
   logic [DW-1:0] resp_regs [4] = '{default: '0};
   always @(posedge clk) begin
      if (valid && wr_en)  resp_regs[addr[3:2]] <= wdata;
      if (valid && !wr_en) rdata <= resp_regs[addr[3:2]];
   end

   // monitor
   logic [AW+DW:0] bus_q[$];
   int             bus_cyc_q[$];
   logic [DW:0]    rsp_q[$];
   int             rsp_cyc_q[$];
   always @(negedge clk) begin
      if (!reset) begin
         if (valid) begin
            bus_q.push_back({wr_en, addr, wdata});
            bus_cyc_q.push_back(cyc);
         end
         if (rsp_valid) begin
            rsp_q.push_back({rsp_err, rsp_rdata});
            rsp_cyc_q.push_back(cyc);
         end
      end
   end

   // scoreboard
   logic [AW+DW:0] exp_bus_q[$];
   logic [DW:0]    exp_rsp_q[$];
   logic [DW-1:0]  exp_regs [4] = '{default: '0};
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(input logic [AW-1:0] a);
      return (a == 32'h400) || (a == 32'h404) || (a == 32'h408) || (a == 32'h40C);
   endfunction

   task automatic clear_obs();
      bus_q.delete();
      bus_cyc_q.delete();
      rsp_q.delete();
      rsp_cyc_q.delete();
      exp_bus_q.delete();
      exp_rsp_q.delete();
   endtask

   // driver
   int acc_cyc;
   int stall_cycles;
   int stall_level;

   task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int waited = 0;
      cmd_valid   = 1'b1;
      cmd_wr      = wr;
      cmd_addr    = a;
      cmd_wdata   = d;
      stall_level = -1;
      while (!cmd_ready && waited < 50) begin
         stall_level = int'(fifo_level);
         @(posedge clk); #1;
         waited++;
      end
      stall_cycles = waited;
      if (!cmd_ready) begin
         check("push_timeout", 128'(cmd_ready), 128'(1));
      end else begin
         @(posedge clk); #1;
         acc_cyc = cyc;
         if (!is_legal(a)) begin
            exp_rsp_q.push_back({1'b1, DW'(0)});
         end else if (wr) begin
            exp_bus_q.push_back({1'b1, a, d});
            exp_regs[a[3:2]] = d;
         end else begin
            exp_bus_q.push_back({1'b0, a, d});
            exp_rsp_q.push_back({1'b0, exp_regs[a[3:2]]});
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) check("idle_timeout", 128'(busy), 128'(0));
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic compare_queues(input string tag);
      int n;
      check({tag, "_bus_count"}, 128'(bus_q.size()), 128'(exp_bus_q.size()));
      n = (bus_q.size() < exp_bus_q.size()) ? bus_q.size() : exp_bus_q.size();
      for (int i = 0; i < n; i++) check({tag, "_bus_entry"}, 128'(bus_q[i]), 128'(exp_bus_q[i]));
      check({tag, "_rsp_count"}, 128'(rsp_q.size()), 128'(exp_rsp_q.size()));
      n = (rsp_q.size() < exp_rsp_q.size()) ? rsp_q.size() : exp_rsp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_rsp_entry"}, 128'(rsp_q[i]), 128'(exp_rsp_q[i]));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},      128'(valid),      128'(0));
      check({tag, "_wr_en"},      128'(wr_en),      128'(0));
      check({tag, "_addr"},       128'(addr),       128'(0));
      check({tag, "_wdata"},      128'(wdata),      128'(0));
      check({tag, "_rsp_valid"},  128'(rsp_valid),  128'(0));
      check({tag, "_rsp_rdata"},  128'(rsp_rdata),  128'(0));
      check({tag, "_rsp_err"},    128'(rsp_err),    128'(0));
      check({tag, "_state"},      128'(state_dbg),  128'(0));
      check({tag, "_fifo_level"}, 128'(fifo_level), 128'(0));
      check({tag, "_busy"},       128'(busy),       128'(0));
   endtask

   logic [DW-1:0]  saved_regs [4];
   logic [AW+DW:0] keep_bus;
   logic [DW:0]    keep_rsp;
   int             e0;

   initial begin
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_wr    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("ready_after_reset", 128'(cmd_ready), 128'(1));
      @(posedge clk); #1;
      check("ready_first_cycle", 128'(cmd_ready), 128'(1));

      // single legal write: one strobe, no response
      clear_obs();
      push_cmd(1'b1, 32'h404, 32'hA5A5_0001);
      e0 = acc_cyc;
      wait_idle();
      compare_queues("t1");
      if (bus_cyc_q.size() > 0) check("t1_valid_edge", 128'(bus_cyc_q[0]), 128'(e0 + 1));

      // write then read back with exact latency
      clear_obs();
      push_cmd(1'b1, 32'h408, 32'h0000_1234);
      wait_idle();
      compare_queues("t2w");
      clear_obs();
      push_cmd(1'b0, 32'h408, 32'h0);
      e0 = acc_cyc;
      wait_idle();
      compare_queues("t2r");
      if (bus_cyc_q.size() > 0) check("t2_valid_edge", 128'(bus_cyc_q[0]), 128'(e0 + 1));
      if (rsp_cyc_q.size() > 0) check("t2_rsp_edge", 128'(rsp_cyc_q[0]), 128'(e0 + 3));
      check("t2_rdata_hold", 128'(rsp_rdata), 128'(32'h1234));
      check("t2_err_hold", 128'(rsp_err), 128'(0));

      // illegal addresses: error response, no strobe
      clear_obs();
      push_cmd(1'b0, 32'h410, 32'h0);
      e0 = acc_cyc;
      wait_idle();
      compare_queues("t3a");
      if (rsp_cyc_q.size() > 0) check("t3_rsp_edge", 128'(rsp_cyc_q[0]), 128'(e0 + 1));
      clear_obs();
      push_cmd(1'b0, 32'h402, 32'h0);
      wait_idle();
      compare_queues("t3b");
      check("t3_err_hold", 128'(rsp_err), 128'(1));

      // fill the FIFO behind two reads; fifth command of the burst must stall
      clear_obs();
      push_cmd(1'b0, 32'h400, 32'h0);
      push_cmd(1'b0, 32'h404, 32'h0);
      push_cmd(1'b0, 32'h408, 32'h0);
      push_cmd(1'b0, 32'h40C, 32'h0);
      push_cmd(1'b0, 32'h400, 32'h0);
      check("t4_push_pop_level", 128'(fifo_level), 128'(3));
      push_cmd(1'b0, 32'h404, 32'h0);
      check("t4_full_level", 128'(fifo_level), 128'(4));
      check("t4_full_ready", 128'(cmd_ready), 128'(0));
      push_cmd(1'b1, 32'h408, 32'h0BAD_F00D);
      check("t4_stalled", 128'(stall_cycles > 0), 128'(1));
      check("t4_stall_level", 128'(stall_level), 128'(4));
      wait_idle();
      compare_queues("t4");

      // continuous stream of alternating writes and reads
      clear_obs();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) begin
            push_cmd(1'b1, 32'h400 + 32'(4 * k), 32'hC0DE_0000 + 32'(16 * r + k));
            push_cmd(1'b0, 32'h400 + 32'(4 * k), 32'h0);
         end
      end
      wait_idle();
      compare_queues("t5");

      // reset while a read is on the bus with three commands queued
      clear_obs();
      saved_regs = exp_regs;
      push_cmd(1'b0, 32'h40C, 32'h0);
      push_cmd(1'b0, 32'h400, 32'h0);
      push_cmd(1'b1, 32'h404, 32'hDEAD_0001);
      push_cmd(1'b0, 32'h408, 32'h0);
      push_cmd(1'b1, 32'h40C, 32'hDEAD_0003);
      check("t6_pre_state", 128'(state_dbg), 128'(1));
      check("t6_pre_level", 128'(fifo_level), 128'(3));
      check("t6_pre_valid", 128'(valid), 128'(1));
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("t6");
      exp_regs = saved_regs;
      keep_bus = exp_bus_q[0];
      keep_rsp = exp_rsp_q[0];
      exp_bus_q.delete();
      exp_rsp_q.delete();
      exp_bus_q.push_back(keep_bus);
      exp_rsp_q.push_back(keep_rsp);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("t6_ready_after_reset", 128'(cmd_ready), 128'(1));
      repeat (8) @(posedge clk);
      #1;
      check("t6_busy_after", 128'(busy), 128'(0));
      compare_queues("t6");

      // recovery: a read after reset returns the last committed value
      clear_obs();
      push_cmd(1'b0, 32'h40C, 32'h0);
      wait_idle();
      compare_queues("t7");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
